mux_scan_n: RTL



---
 rtl/mux_scan_pkg.sv | 23 ++
 rtl/mux_nx1.sv | 29 ++
 rtl/mux_scan_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared types and helpers for the mux_scan_n block.
//   - state_e     : request FSM state (idle / emitting beats / done pulse)
//   - MODE_MANUAL : single beat from the captured select
//   - MODE_SCAN   : burst over every (enabled) channel in ascending order
//   - sel_width() : channel-index width for a given channel count
package mux_scan_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEmit = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Never narrower than one bit, so a select port always exists.
    function automatic int unsigned sel_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// mux_nx1
//   Purely combinational N_CH-to-1 selector, W bits per channel.
//   Ports:
//     data : packed channels, channel c at bits [c*W +: W]
//     sel  : channel index
//     y    : selected channel, or zero when sel >= N_CH
module mux_nx1
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH*W-1:0] data,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      y
);

    // Out-of-range selects match no channel and fall through to zero.
    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                y = data[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n
//   Registered N_CH x W multiplexer with a valid/ready output. A start pulse in
//   idle launches either one beat from sel_in (manual) or a burst over all
//   channels in ascending order (scan). Each beat is a snapshot of data_in
//   taken on the edge that loads it.
//
//   Optional feature: define MUX_SCAN_MASK_EN to add a ch_mask input; scan then
//   visits only channels whose mask bit is set (captured at start).
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     data_in    : packed channel data, channel c at [c*W +: W]
//     mode       : MODE_MANUAL / MODE_SCAN, captured at start
//     sel_in     : manual channel, captured at start
//     start      : request pulse, only honoured in idle
//     out_ready  : consumer accepts the current beat
//     ch_mask    : (MUX_SCAN_MASK_EN only) scan channel enables
//     out_valid  : beat present on out_data/out_ch/out_last
//     out_data   : registered channel data
//     out_ch     : channel index of the current beat
//     out_last   : final beat of the request
//     busy       : request in progress
//     done       : one-cycle pulse after the final beat transfers
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int unsigned  N_CH  = 8,
    parameter int unsigned  W     = 8,
    localparam int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] data_in,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              start,
    input  logic              out_ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ch_q, ch_d;   // doubles as the scan counter and the captured sel_in
    logic             last_q, last_d;
    logic [W-1:0]     data_q;
    logic             load;
    logic [W-1:0]     mux_y;

    // Effective scan enables: at start they come straight from the inputs,
    // during the burst from the captured copy.
    logic [N_CH-1:0]  start_mask;
    logic [N_CH-1:0]  run_mask;

`ifdef MUX_SCAN_MASK_EN
    logic [N_CH-1:0]  mask_q, mask_d;
    assign start_mask = ch_mask;
    assign run_mask   = mask_q;
`else
    assign start_mask = '1;
    assign run_mask   = '1;
`endif

    // ------------------------------------------------------------------
    // Next-enabled-channel search: lowest enabled channel at or above
    // srch_lo, and whether it is the highest enabled channel.
    // ------------------------------------------------------------------
    logic [N_CH-1:0]  srch_mask;
    int unsigned      srch_lo;
    logic             nxt_found;
    logic [SEL_W-1:0] nxt_ch;
    logic             nxt_last;

    always_comb begin
        srch_mask = (state_q == StIdle) ? start_mask : run_mask;
        srch_lo   = (state_q == StIdle) ? 32'd0 : 32'(ch_q) + 32'd1;
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!nxt_found && srch_mask[i] && (i >= srch_lo)) begin
                nxt_found = 1'b1;
                nxt_ch    = SEL_W'(i);
            end
        end
        nxt_last = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (srch_mask[i] && (i > 32'(nxt_ch))) begin
                nxt_last = 1'b0;
            end
        end
    end

    // The mux looks at the channel being loaded this edge, so the data
    // snapshot and out_ch always belong to the same beat.
    mux_nx1 #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mux (
        .data (data_in),
        .sel  (ch_d),
        .y    (mux_y)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= MODE_MANUAL;
            valid_q <= 1'b0;
            ch_q    <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            if (load) begin
                data_q <= mux_y;
            end
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        last_d  = last_q;
        load    = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        mask_d  = mask_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
`ifdef MUX_SCAN_MASK_EN
                    mask_d = ch_mask;
`endif
                    if (mode == MODE_MANUAL) begin
                        state_d = StEmit;
                        valid_d = 1'b1;
                        ch_d    = sel_in;
                        last_d  = 1'b1;
                        load    = 1'b1;
                    end else if (nxt_found) begin
                        state_d = StEmit;
                        valid_d = 1'b1;
                        ch_d    = nxt_ch;
                        last_d  = nxt_last;
                        load    = 1'b1;
                    end else begin
                        // Nothing enabled: skip straight to the done pulse.
                        state_d = StDone;
                    end
                end
            end

            StEmit: begin
                if (valid_q && out_ready) begin
                    if (last_q || (mode_q == MODE_MANUAL)) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        // Back-to-back: next beat loads on the transfer edge.
                        ch_d   = nxt_ch;
                        last_d = nxt_last;
                        load   = 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all driven from registers)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = valid_q;
        out_data  = data_q;
        out_ch    = ch_q;
        out_last  = last_q;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

    // A stalled beat must not change under the consumer.
    stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_ch) && $stable(out_last)));

    done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
